muldiv_ctrl: RTL and testbench

Sequencer and HI/LO owner for the iterative multiply/divide datapath of the multicycle MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the control unit and launches the 32-iteration multiplier or divider. Counts the iteration latency, commits results into the architectural HI/LO registers, and stalls MFHI/MFLO reads until those results are committed.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/hilo_regs.sv | 38 +++
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default latencies
// for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam int MULT_LAT = 33;
    localparam int DIV_LAT  = 33;
    localparam int CNT_W    = 6;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO storage with independent write
// enables and the combinational MFHI/MFLO read mux.
module hilo_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] hi_wd_i,
    input  logic [31:0] lo_wd_i,
    input  logic        mf_sel_i,
    output logic [31:0] mf_data_o
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we_i) hi_d = hi_wd_i;
        if (lo_we_i) lo_d = lo_wd_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign mf_data_o = mf_sel_i ? hi_q : lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: launches the iterative mul/div units, counts their
// latency, commits HI/LO and stalls MFHI/MFLO while busy.
module muldiv_ctrl #(
    parameter int MULT_LAT = muldiv_pkg::MULT_LAT,
    parameter int DIV_LAT  = muldiv_pkg::DIV_LAT,
    parameter int CNT_W    = muldiv_pkg::CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    output logic        op_ready,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        abort,
    output logic        mult_init,
    output logic        div_init,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_signed,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        busy,
    output logic        div_zero
);

    import muldiv_pkg::*;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             sg_q, sg_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             hi_we;
    logic             lo_we;
    logic [31:0]      hi_wd;
    logic [31:0]      lo_wd;
    op_e              op_in;

    assign op_in  = op_e'(op);
    assign accept = op_valid & (state_q == S_IDLE) & ~abort;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        sg_d     = sg_q;
        dz_d     = dz_q;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wd    = rs_val;
        lo_wd    = rs_val;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (op_in)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d  = S_LAUNCH;
                            a_d      = rs_val;
                            b_d      = rt_val;
                            sg_d     = op_is_signed(op_in);
                            is_div_d = op_is_div(op_in);
                            if (op_is_div(op_in) && rt_val == '0)
                                dz_d = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_we = 1'b1;
                            dz_d  = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_we = 1'b1;
                            dz_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_LAUNCH: begin
                cnt_d   = is_div_q ? DIV_LD : MULT_LD;
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // abort beats a same-edge commit
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_wd   = is_div_q ? div_hi : mult_hi;
                    lo_wd   = is_div_q ? div_lo : mult_lo;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sg_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sg_q     <= sg_d;
            dz_q     <= dz_d;
        end
    end

    hilo_regs u_hilo (
        .clk       (clk),
        .reset     (reset),
        .hi_we_i   (hi_we),
        .lo_we_i   (lo_we),
        .hi_wd_i   (hi_wd),
        .lo_wd_i   (lo_wd),
        .mf_sel_i  (mf_sel),
        .mf_data_o (mf_data)
    );

    logic launch_ok;
    assign launch_ok = (state_q == S_LAUNCH) & ~abort & ~reset;

    assign mult_init   = launch_ok & ~is_div_q;
    assign div_init    = launch_ok &  is_div_q;
    assign op_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign stall       = mf_req & busy;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign unit_signed = sg_q;
    assign div_zero    = dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed + random checks of muldiv_ctrl against an
// arithmetic HI/LO model, with delay-line models of the mul/div units.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic        op_ready;
    logic [31:0] rs_val, rt_val;
    logic        abort;
    logic        mult_init, div_init;
    logic [31:0] unit_a, unit_b;
    logic        unit_signed;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic        mf_req, mf_sel;
    logic [31:0] mf_data;
    logic        stall, busy, div_zero;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .op_ready(op_ready), .rs_val(rs_val), .rt_val(rt_val),
        .abort(abort), .mult_init(mult_init), .div_init(div_init),
        .unit_a(unit_a), .unit_b(unit_b), .unit_signed(unit_signed),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_hi(div_hi), .div_lo(div_lo),
        .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data),
        .stall(stall), .busy(busy), .div_zero(div_zero)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // result a unit returns: {hi, lo}
    function automatic logic [63:0] unit_res(input bit dv, input bit sg,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (!dv) return sg ? 64'(sa * sb) : 64'(ua * ub);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) return {32'(sa % sb), 32'(sa / sb)};
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    // delay-line unit models; garbage until the latency has elapsed
    int          m_cnt = -1, d_cnt = -1;
    logic [31:0] ma, mb, da, db;
    logic        ms, ds;

    always @(posedge clk) begin
        if (mult_init) begin
            ma <= unit_a; mb <= unit_b; ms <= unit_signed;
            m_cnt <= MULT_LAT - 1;
        end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
        if (div_init) begin
            da <= unit_a; db <= unit_b; ds <= unit_signed;
            d_cnt <= DIV_LAT - 1;
        end else if (d_cnt > 0) d_cnt <= d_cnt - 1;
    end

    assign {mult_hi, mult_lo} = (m_cnt == 0) ?
        unit_res(1'b0, ms, ma, mb) : {2{32'hDEAD_BEEF}};
    assign {div_hi, div_lo} = (d_cnt == 0) ?
        unit_res(1'b1, ds, da, db) : {2{32'hBAD0_BAD0}};

    // reference architectural state
    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    int          r_busy, r_mi, r_di, r_ic;
    logic [31:0] r_ua, r_ub;
    logic        r_us, r_dz0;

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        mf_sel = 1'b1; #1; hi = mf_data;
        mf_sel = 1'b0; #1; lo = mf_data;
    endtask

    // present op in IDLE, abort at busy cycle ac (ac<0: never)
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int ac);
        int c;
        r_busy = 0; r_mi = 0; r_di = 0; r_ic = -1;
        r_ua = '0; r_ub = '0; r_us = 1'b0; r_dz0 = 1'b0;
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        c = 0;
        while (busy && c < 100) begin
            abort = (c == ac);
            #1;
            if (c == 0) begin
                r_ua = unit_a; r_ub = unit_b;
                r_us = unit_signed; r_dz0 = div_zero;
            end
            if (mult_init) begin r_mi++; if (r_ic < 0) r_ic = c; end
            if (div_init)  begin r_di++; if (r_ic < 0) r_ic = c; end
            r_busy++;
            @(negedge clk);
            abort = 1'b0;
            c++;
        end
        chk("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic apply(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int ac);
        bit          uop, dv, sg, killed, fired;
        int          eb;
        logic [63:0] res;
        logic [31:0] hi, lo;
        uop    = (o < 3'd4);
        dv     = (o == 3'd2) || (o == 3'd3);
        sg     = (o == 3'd0) || (o == 3'd2);
        killed = uop && ac >= 0 && ac <= 33;
        fired  = uop && ac != 0;
        eb     = !uop ? 0 : (killed ? ac + 1 : 34);
        run_op(o, a, b, ac);
        chk("busy_cycles", 32'(r_busy), 32'(eb));
        chk("mult_init_n", 32'(r_mi), 32'(fired && !dv));
        chk("div_init_n", 32'(r_di), 32'(fired && dv));
        if (fired) chk("init_cycle", 32'(r_ic), 32'd0);
        if (uop) begin
            if (dv && b == 32'd0) m_dz = 1'b1;
            chk("unit_a", r_ua, a);
            chk("unit_b", r_ub, b);
            chk("unit_signed", 32'(r_us), 32'(sg));
            chk("dz_at_accept", 32'(r_dz0), 32'(m_dz));
            if (!killed) begin
                res = unit_res(dv, sg, a, b);
                m_hi = res[63:32];
                m_lo = res[31:0];
            end
        end else if (o == 3'd4) begin
            m_hi = a; m_dz = 1'b0;
        end else if (o == 3'd5) begin
            m_lo = a; m_dz = 1'b0;
        end
        read_hilo(hi, lo);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_zero", 32'(div_zero), 32'(m_dz));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] hi, lo, a, b;
        logic [2:0]  o;
        int          n, ac;

        reset = 1'b1; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        abort = 1'b0; mf_req = 1'b0; mf_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_in_reset", 32'({mult_init, div_init}), 32'd0);
        reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("rst_unit_a", unit_a, 32'd0);
        chk("rst_unit_b", unit_b, 32'd0);
        chk("rst_signed", 32'(unit_signed), 32'd0);
        read_hilo(hi, lo);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // MULT 7 * -3
        apply(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
        read_hilo(hi, lo);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        // DIVU 100 / 7 with MFHI waiting on the result
        op_valid = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        chk("divu_init", 32'(div_init), 32'd1);
        chk("divu_signed", 32'(unit_signed), 32'd0);
        @(negedge clk);
        mf_req = 1'b1; mf_sel = 1'b1;
        n = 0;
        #1;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("mfhi_stall_cycles", 32'(n), 32'd33);
        chk("mfhi_data", mf_data, 32'd2);
        mf_req = 1'b0;
        m_hi = 32'd2; m_lo = 32'd14;
        read_hilo(hi, lo);
        chk("divu_lo", lo, 32'd14);

        // MTHI blocked by abort in IDLE, then accepted
        @(negedge clk);
        op_valid = 1'b1; op = 3'd4; rs_val = 32'h1234_5678; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; op_valid = 1'b0;
        read_hilo(hi, lo);
        chk("mthi_aborted", hi, 32'd2);
        apply(3'd4, 32'h1234_5678, 32'd0, -1);

        // MTLO held while a MULT runs
        op_valid = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd5;
        @(posedge clk);
        @(negedge clk);
        op = 3'd5; rs_val = 32'hA5A5_A5A5;
        n = 0;
        #1;
        while (!op_ready && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk("held_wait", 32'(n), 32'd34);
        m_hi = 32'd0; m_lo = 32'hA5A5_A5A5;
        read_hilo(hi, lo);
        chk("held_hi", hi, m_hi);
        chk("held_lo", lo, m_lo);

        // divide by zero is sticky until MTLO
        apply(3'd2, 32'd55, 32'd0, -1);
        apply(3'd5, 32'd77, 32'd0, -1);

        // aborts: RUN cnt==5, LAUNCH, same edge as commit
        apply(3'd0, 32'd1000, 32'd1000, 28);
        apply(3'd0, 32'd9, 32'd9, 0);
        apply(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        // reset during RUN
        op_valid = 1'b1; op = 3'd1; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        chk("rrun_busy", 32'(busy), 32'd0);
        chk("rrun_ready", 32'(op_ready), 32'd1);
        read_hilo(hi, lo);
        chk("rrun_hi", hi, 32'd0);
        chk("rrun_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        read_hilo(hi, lo);
        chk("rrun_no_commit", hi | lo, 32'd0);

        // random ops
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            ac = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 33)) : -1;
            apply(o, a, b, ac);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
